pow2_classifier: RTL and testbench
==================================

POW2_CLASSIFIER -- requirements
Module: pow2_classifier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter EXP_W, default $clog2(WIDTH), giving the exponent output width.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the hit counter width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, operand present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, operand accepted when in_valid and in_ready are both high.
REQ-008 The block SHALL have port x, input, WIDTH bits, the operand; bit 0 is the LSB.
REQ-009 The block SHALL have port out_valid, output, 1 bit, result present.
REQ-010 The block SHALL have port out_ready, input, 1 bit, result consumed when out_valid and out_ready are both high.
REQ-011 The block SHALL have port z, output, 1 bit, high when the operand has exactly one bit set.
REQ-012 The block SHALL have port exp, output, EXP_W bits, the index of the set bit when z=1, else 0.
REQ-013 The block SHALL have port is_zero, output, 1 bit, high when the operand is all zeros.
REQ-014 The block SHALL have port cnt_clr, input, 1 bit, synchronous clear of the hit counter.
REQ-015 The block SHALL have port hit_cnt, output, CNT_W bits, the number of accepted operands with z=1 (present only under POW2_COUNT_EN).

Function
REQ-016 The block SHALL register the result of each accepted operand into a one-entry output register; latency is exactly 1 cycle from acceptance to out_valid.
REQ-017 The block SHALL drive in_ready = !out_valid || out_ready (combinational), sustaining one operand per cycle while out_ready=1.
REQ-018 The block SHALL hold out_valid, z, exp and is_zero stable while out_valid=1 and out_ready=0.
REQ-019 The block SHALL load a new result when the output is consumed and a new operand is accepted in the same cycle; out_valid then stays 1.
REQ-020 The block SHALL clear out_valid when the output is consumed and no operand is accepted in the same cycle.
REQ-021 The block SHALL treat x=0 as z=0, exp=0, is_zero=1, and treat x with two or more bits set as z=0, exp=0, is_zero=0.
REQ-022 The block SHALL return exp=WIDTH-1 and z=1 for x with only the MSB set (boundary case).
REQ-023 The block SHALL ignore x whenever in_valid=0, or whenever in_valid=1 and in_ready=0.

Reset
REQ-024 The block SHALL, while rst=1, force out_valid=0, z=0, exp=0, is_zero=0 and hit_cnt=0 at the next clock edge.
REQ-025 The block SHALL discard any pending result when rst asserts while out_valid=1; no handshake completes in a cycle where rst=1.
REQ-026 The block SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-027 The block SHALL include, when macro POW2_COUNT_EN is defined, the hit_cnt port and a counter that increments by 1 on each accepted operand with one-hot x.
REQ-028 The counter SHALL saturate at 2^CNT_W-1.
REQ-029 cnt_clr SHALL zero the counter and take priority over a simultaneous increment, giving a result of 0.
REQ-030 The block SHALL, when POW2_COUNT_EN is undefined, omit the hit_cnt port and counter logic, and SHALL ignore cnt_clr.

Structure
REQ-031 Package pow2_pkg SHALL hold a result struct {z, is_zero, exp} parametrised by width via a localparam default of 8, plus the function onehot_idx.
REQ-032 Combinational classification SHALL live in sub-module pow2_onehot_enc (inputs x; outputs z, exp, is_zero); pow2_classifier holds the handshake, output register and counter.

Verification
REQ-033 The bench SHALL cover, with WIDTH=8 and out_ready=1: x=8'b00000111, 8'b00000100, 8'b01000000, 8'b00010000 on consecutive cycles -> outputs (z,exp) = (0,0), (1,2), (1,6), (1,4), each 1 cycle later.
REQ-034 The bench SHALL cover x=8'h00 -> z=0, is_zero=1, exp=0; and x=8'h80 -> z=1, exp=7.
REQ-035 The bench SHALL cover backpressure: out_ready=0 for 3 cycles after x=8'h10 is accepted -> in_ready=0, output held at z=1, exp=4; after out_ready=1, the next operand is accepted in the same cycle.
REQ-036 The bench SHALL cover the counter (POW2_COUNT_EN, CNT_W=2): 5 accepted one-hot operands -> hit_cnt=3 (saturated); cnt_clr together with a one-hot acceptance -> hit_cnt=0.
REQ-037 The bench SHALL cover reset: rst=1 while out_valid=1 -> next cycle out_valid=0, hit_cnt=0, in_ready=1.
REQ-038 The bench SHALL cover parameter sweep: WIDTH=16 with x=16'h8000 -> exp=15; WIDTH=32 with x=32'h0001_0001 -> z=0.

Source files
------------

// File: rtl/pow2_pkg.sv
// Shared types and helpers for the power-of-two classifier.
// The optional hit counter is built when POW2_COUNT_EN is defined.
package pow2_pkg;

    localparam int RES_WIDTH = 8;
    localparam int RES_EXP_W = $clog2(RES_WIDTH);

    typedef struct packed {
        logic                 z;
        logic                 is_zero;
        logic [RES_EXP_W-1:0] exp;
    } pow2_result_t;

    // Index of the lowest set bit; only meaningful when v is one-hot.
    function automatic int onehot_idx(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/pow2_onehot_enc.sv
// Combinational classifier: one-hot detect, bit index and zero detect.
module pow2_onehot_enc
    import pow2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EXP_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] x,
    output logic             z,
    output logic [EXP_W-1:0] exp,
    output logic             is_zero
);

    int idx;

    // A value is one-hot when it is nonzero and clearing its lowest set bit leaves zero.
    assign is_zero = (x == '0);
    assign z       = !is_zero && ((x & (x - WIDTH'(1))) == '0);
    assign idx     = onehot_idx(64'(x));
    assign exp     = z ? EXP_W'(idx) : '0;

endmodule

// File: rtl/pow2_classifier.sv
// Power-of-two classifier with a one-entry registered output stage.
// Defining POW2_COUNT_EN adds the saturating hit counter and the hit_cnt port.
module pow2_classifier
    import pow2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EXP_W = $clog2(WIDTH),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             z,
    output logic [EXP_W-1:0] exp,
    output logic             is_zero,
    input  logic             cnt_clr
`ifdef POW2_COUNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    // Handshake: a beat transfers on a rising edge where valid && ready; the
    // producer holds data stable until then, and nothing transfers while rst=1.
    logic             enc_z;
    logic [EXP_W-1:0] enc_exp;
    logic             enc_is_zero;
    logic             accept;

    pow2_onehot_enc #(
        .WIDTH (WIDTH),
        .EXP_W (EXP_W)
    ) u_enc (
        .x       (x),
        .z       (enc_z),
        .exp     (enc_exp),
        .is_zero (enc_is_zero)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            z         <= 1'b0;
            exp       <= '0;
            is_zero   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            z         <= enc_z;
            exp       <= enc_exp;
            is_zero   <= enc_is_zero;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef POW2_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            hit_cnt <= '0;
        end else if (accept && enc_z && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = cnt_clr;
`endif

endmodule

// File: tb/tb_pow2_classifier.sv
// Directed self-checking bench for pow2_classifier (WIDTH 8/16/32 instances).
// Counter checks are compiled in when POW2_COUNT_EN is defined.
module tb_pow2_classifier;

    logic clk = 1'b0;
    logic rst;
    logic out_ready;
    logic cnt_clr;

    logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_z, d8_is_zero;
    logic [7:0]  d8_x;
    logic [2:0]  d8_exp;
    logic        d16_in_valid, d16_in_ready, d16_out_valid, d16_z, d16_is_zero;
    logic [15:0] d16_x;
    logic [3:0]  d16_exp;
    logic        d32_in_valid, d32_in_ready, d32_out_valid, d32_z, d32_is_zero;
    logic [31:0] d32_x;
    logic [4:0]  d32_exp;
`ifdef POW2_COUNT_EN
    logic [1:0]  d8_hit_cnt;
    logic [15:0] d16_hit_cnt;
    logic [15:0] d32_hit_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    pow2_classifier #(.WIDTH(8), .CNT_W(2)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready), .x(d8_x),
        .out_valid(d8_out_valid), .out_ready(out_ready), .z(d8_z), .exp(d8_exp),
        .is_zero(d8_is_zero), .cnt_clr(cnt_clr)
`ifdef POW2_COUNT_EN
        , .hit_cnt(d8_hit_cnt)
`endif
    );

    pow2_classifier #(.WIDTH(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(d16_in_valid), .in_ready(d16_in_ready), .x(d16_x),
        .out_valid(d16_out_valid), .out_ready(out_ready), .z(d16_z), .exp(d16_exp),
        .is_zero(d16_is_zero), .cnt_clr(cnt_clr)
`ifdef POW2_COUNT_EN
        , .hit_cnt(d16_hit_cnt)
`endif
    );

    pow2_classifier #(.WIDTH(32)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(d32_in_valid), .in_ready(d32_in_ready), .x(d32_x),
        .out_valid(d32_out_valid), .out_ready(out_ready), .z(d32_z), .exp(d32_exp),
        .is_zero(d32_is_zero), .cnt_clr(cnt_clr)
`ifdef POW2_COUNT_EN
        , .hit_cnt(d32_hit_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] vec [4];
        vec = '{8'h07, 8'h04, 8'h40, 8'h10};
        exp_q = '{4'b0_000, 4'b1_010, 4'b1_110, 4'b1_100};

        rst = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
        d8_in_valid = 1'b0; d8_x = '0;
        d16_in_valid = 1'b0; d16_x = '0;
        d32_in_valid = 1'b0; d32_x = '0;
        step();
        step();
        check("reset_out_valid", d8_out_valid, 0);
        check("reset_z", d8_z, 0);
        check("reset_exp", d8_exp, 0);
        check("reset_is_zero", d8_is_zero, 0);
`ifdef POW2_COUNT_EN
        check("reset_hit_cnt", d8_hit_cnt, 0);
`endif
        rst = 1'b0;
        check("post_reset_in_ready", d8_in_ready, 1);

        // Back-to-back stream, one result per cycle.
        for (int i = 0; i < 4; i++) begin
            d8_in_valid = 1'b1;
            d8_x = vec[i];
            step();
            check("stream_out_valid", d8_out_valid, 1);
            check("stream_z_exp", {d8_z, d8_exp}, exp_q.pop_front());
            check("stream_is_zero", d8_is_zero, 0);
        end
        d8_in_valid = 1'b0;
        step();
        check("drain_out_valid", d8_out_valid, 0);

        d8_in_valid = 1'b1; d8_x = 8'h00;
        step();
        check("zero_z", d8_z, 0);
        check("zero_is_zero", d8_is_zero, 1);
        check("zero_exp", d8_exp, 0);
        d8_x = 8'h80;
        step();
        check("msb_z", d8_z, 1);
        check("msb_exp", d8_exp, 7);
        check("msb_is_zero", d8_is_zero, 0);
        d8_in_valid = 1'b0;
        step();

        // Backpressure: result must hold while out_ready is low.
        d8_in_valid = 1'b1; d8_x = 8'h10; out_ready = 1'b0;
        step();
        d8_x = 8'h01;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", d8_in_ready, 0);
            check("bp_out_valid", d8_out_valid, 1);
            check("bp_hold", {d8_z, d8_exp}, 4'b1_100);
            step();
        end
        d8_x = 8'h20; out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", d8_in_ready, 1);
        step();
        check("bp_new_out_valid", d8_out_valid, 1);
        check("bp_new_result", {d8_z, d8_exp}, 4'b1_101);
        d8_in_valid = 1'b0;
        step();
        check("bp_drain", d8_out_valid, 0);

`ifdef POW2_COUNT_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_cleared", d8_hit_cnt, 0);
        d8_in_valid = 1'b1; d8_x = 8'h06;
        step();
        check("cnt_non_onehot", d8_hit_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            d8_x = 8'h01 << i;
            step();
            check("cnt_inc", d8_hit_cnt, (i < 3) ? i + 1 : 3);
        end
        d8_x = 8'h08; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_clr_priority", d8_hit_cnt, 0);
        d8_in_valid = 1'b0;
        step();
`endif

        // Reset while a result is pending.
        d8_in_valid = 1'b1; d8_x = 8'h02; out_ready = 1'b0;
        step();
        check("pre_rst_out_valid", d8_out_valid, 1);
        d8_in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b1;
        check("rst_out_valid", d8_out_valid, 0);
        check("rst_z", d8_z, 0);
        check("rst_exp", d8_exp, 0);
`ifdef POW2_COUNT_EN
        check("rst_hit_cnt", d8_hit_cnt, 0);
`endif
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", d8_in_ready, 1);
        out_ready = 1'b1;
        step();

        // Wider parameterisations.
        d16_in_valid = 1'b1; d16_x = 16'h8000;
        d32_in_valid = 1'b1; d32_x = 32'h0001_0001;
        step();
        d16_in_valid = 1'b0; d32_in_valid = 1'b0;
        check("w16_out_valid", d16_out_valid, 1);
        check("w16_z", d16_z, 1);
        check("w16_exp", d16_exp, 15);
        check("w32_out_valid", d32_out_valid, 1);
        check("w32_z", d32_z, 0);
        check("w32_exp", d32_exp, 0);
        check("w32_is_zero", d32_is_zero, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
